osc_measure_sequencer: RTL
==========================

// Module: osc_measure_sequencer
// PURPOSE
//  OPB-side bus master driving the oscillator counter slave (CNTRLR/CLKDIVR/COUNTR/SPR map).
//  Verifies the bus path once via a scratch-pad write/readback.
//  Then runs a periodic loop: counter reset, start, fixed wait, COUNTR read, range check.
//  Publishes the last count, an in-range flag and a sticky FAULT for the supervisor.
// PARAMETERS
//  MEAS_WAIT   64      OPB_CLK cycles from START write to COUNTR read; must exceed 2 REF_CLK periods
//  GAP_CYCLES  1024    idle OPB_CLK cycles between measurements
//  FAIL_LIMIT  3       consecutive out-of-range samples that set FAULT (1..15)
//  SP_PATTERN  16'hA5C3  scratch-pad test value
// PORTS
//  OPB_CLK     in   1   single clock, 32 MHz
//  OPB_RST     in   1   asynchronous, active-high reset
//  ENABLE      in   1   run request; low returns FSM to IDLE and clears sticky flags
//  CNT_MIN     in   16  inclusive lower count limit, sampled in EVAL
//  CNT_MAX     in   16  inclusive upper count limit, sampled in EVAL
//  OPB_ADDR    out  32  slave register address (only [1:0] non-zero)
//  OSC_CT_DI   out  32  write data to slave
//  OSC_CT_WE   out  1   single-cycle write strobe
//  OSC_CT_RE   out  1   single-cycle read strobe
//  OSC_CT_DO   in   32  slave read data, registered, valid the cycle after OSC_CT_RE
//  LAST_COUNT  out  16  most recent captured (or averaged) count
//  COUNT_VALID out  1   one-cycle pulse when LAST_COUNT updates
//  IN_RANGE    out  1   CNT_MIN <= LAST_COUNT <= CNT_MAX, unsigned compare
//  FAULT       out  1   sticky; set after FAIL_LIMIT consecutive out-of-range samples
//  BUS_ERR     out  1   sticky; scratch-pad readback mismatch
// BEHAVIOUR
//  Reset: all outputs 0 and FSM in IDLE.
//  States:
//  - IDLE: leave to SP_WR when ENABLE=1 and BUS_ERR=0.
//  - SP_WR: WE=1, ADDR=3, DI={16'h0,SP_PATTERN}.
//  - SP_RD: RE=1, ADDR=3.
//  - SP_CHK: compare DO[15:0] to SP_PATTERN. Mismatch sets BUS_ERR, go to IDLE. Match goes to RST_WR.
//  - RST_WR: WE=1, ADDR=0, DI=32'h2.
//  - RST_HOLD: 2 cycles, no strobes.
//  - START_WR: WE=1, ADDR=0, DI=32'h1.
//  - WAIT: MEAS_WAIT cycles.
//  - CNT_RD: RE=1, ADDR=2.
//  - CNT_CAP: capture DO[15:0].
//  - EVAL: update LAST_COUNT/IN_RANGE, pulse COUNT_VALID.
//  - GAP: GAP_CYCLES cycles, then RST_WR. The SPR check is not repeated.
//  Strobes: every strobe is exactly one cycle, RE and WE are never both high, ADDR/DI are stable while a strobe is high. Outside strobes ADDR=0 and DI=0.
//  Latency: START_WR to COUNT_VALID is MEAS_WAIT+3 cycles.
//  Fail counter: 4-bit, saturating at FAIL_LIMIT; cleared by any in-range sample. FAULT sets when the counter reaches FAIL_LIMIT.
//  CNT_MIN > CNT_MAX is legal and yields IN_RANGE=0.
//  ENABLE low in any state: next cycle FSM is in IDLE, strobes 0, FAULT/BUS_ERR/fail counter cleared; LAST_COUNT is held.
//  Reset mid-operation: strobes drop immediately (asynchronous).
//  Counter wrap inside the slave is not detected; 16'hFFFF is treated as a normal value.
// CONFIGURATION
//  OSC_SEQ_AVG_EN defined:
//  - LAST_COUNT is the mean of the last 4 captures: 18-bit sum >> 2, truncating.
//  - COUNT_VALID and the range check stay suppressed until 4 captures exist since leaving IDLE.
//  OSC_SEQ_AVG_EN undefined: LAST_COUNT is the raw capture and every EVAL is checked.
// STRUCTURE
//  Shared package osc_ct_pkg:
//  - register address constants CNTRLR=0, CLKDIVR=1, COUNTR=2, SPR=3;
//  - control bit constants START=bit0, RESET=bit1;
//  - FSM state encoding, 4-bit localparams.
//  One sub-module, osc_range_checker: optional averager, limit compare, fail counter and FAULT latch, fed by capture data and a capture strobe.
// TESTING
//  1 Slave model returns SP readback 16'hA5C3 and count 1000; limits 990/1010 -> COUNT_VALID, LAST_COUNT=1000, IN_RANGE=1, FAULT=0.
//  2 SP readback 16'hA5C2 -> BUS_ERR=1, no further strobes while ENABLE stays high; ENABLE low then high -> retry.
//  3 Counts 1200,1200,1200 with FAIL_LIMIT=3 -> FAULT set on third EVAL; a sample of 1000 then clears the fail counter but FAULT stays 1.
//  4 Bus protocol: check strobe order WE@3, RE@3, WE@0 DI=2, WE@0 DI=1, RE@2; START_WR to COUNT_VALID = 67 cycles with MEAS_WAIT=64.
//  5 ENABLE dropped during WAIT, and OPB_RST asserted during CNT_RD -> strobes 0 within 1 cycle (0 cycles for reset); FSM in IDLE.
//  6 With OSC_SEQ_AVG_EN, counts 1000,1002,1004,1006 -> first COUNT_VALID after fourth capture with LAST_COUNT=1003.

Source files
------------

// File: rtl/osc_ct_pkg.sv
// Register map, control bits and sequencer state encoding shared by
// the oscillator counter bus master and its range checker.
package osc_ct_pkg;

  localparam logic [1:0] CNTRLR  = 2'd0;
  localparam logic [1:0] CLKDIVR = 2'd1;
  localparam logic [1:0] COUNTR  = 2'd2;
  localparam logic [1:0] SPR     = 2'd3;

  localparam int START = 0;
  localparam int RESET = 1;

  localparam logic [31:0] CTL_START = 32'h1 << START;
  localparam logic [31:0] CTL_RESET = 32'h1 << RESET;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SP_WR    = 4'd1,
    ST_SP_RD    = 4'd2,
    ST_SP_CHK   = 4'd3,
    ST_RST_WR   = 4'd4,
    ST_RST_HOLD = 4'd5,
    ST_START_WR = 4'd6,
    ST_WAIT     = 4'd7,
    ST_CNT_RD   = 4'd8,
    ST_CNT_CAP  = 4'd9,
    ST_EVAL     = 4'd10,
    ST_GAP      = 4'd11
  } state_t;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] di;
  } bus_t;

  // Bus drive for the cycle spent in a given state.
  function automatic bus_t bus_for(state_t s, logic [15:0] pat);
    bus_t b;
    b = '0;
    case (s)
      ST_SP_WR: begin
        b.we   = 1'b1;
        b.addr = SPR;
        b.di   = {16'h0, pat};
      end
      ST_SP_RD: begin
        b.re   = 1'b1;
        b.addr = SPR;
      end
      ST_RST_WR: begin
        b.we   = 1'b1;
        b.addr = CNTRLR;
        b.di   = CTL_RESET;
      end
      ST_START_WR: begin
        b.we   = 1'b1;
        b.addr = CNTRLR;
        b.di   = CTL_START;
      end
      ST_CNT_RD: begin
        b.re   = 1'b1;
        b.addr = COUNTR;
      end
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/osc_range_checker.sv
// Optional 4-sample averager, limit compare, fail counter and FAULT latch.
// Averaging is built when OSC_SEQ_AVG_EN is defined.
module osc_range_checker #(
  parameter int FAIL_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        restart,
  input  logic        cap,
  input  logic [15:0] cap_data,
  input  logic [15:0] cnt_min,
  input  logic [15:0] cnt_max,
  output logic [15:0] last_count,
  output logic        count_valid,
  output logic        in_range,
  output logic        fault
);

  localparam logic [3:0] LIM = 4'(FAIL_LIMIT);

  logic [15:0] sample;
  logic        sample_ok;
  logic        ok;
  logic [3:0]  fails;

`ifdef OSC_SEQ_AVG_EN
  logic [2:0][15:0] hist;
  logic [1:0]       ncap;
  logic [17:0]      sum;

  assign sum = 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]) + 18'(cap_data);
  assign sample = 16'(sum >> 2);
  assign sample_ok = (ncap == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      ncap <= '0;
    end else if (restart) begin
      hist <= '0;
      ncap <= '0;
    end else if (cap) begin
      hist <= {hist[1:0], cap_data};
      if (ncap != 2'd3)
        ncap <= ncap + 2'd1;
    end
  end
`else
  logic unused_restart;

  assign unused_restart = restart;
  assign sample = cap_data;
  assign sample_ok = 1'b1;
`endif

  assign ok = (sample >= cnt_min) && (sample <= cnt_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_count  <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      fault       <= 1'b0;
      fails       <= '0;
    end else begin
      count_valid <= 1'b0;
      if (clr) begin
        fault <= 1'b0;
        fails <= '0;
      end else if (cap && sample_ok) begin
        last_count  <= sample;
        count_valid <= 1'b1;
        in_range    <= ok;
        if (ok) begin
          fails <= '0;
        end else begin
          if (fails < LIM)
            fails <= fails + 4'd1;
          // this sample is the one that brings the run to the limit
          if (fails >= LIM - 4'd1)
            fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/osc_measure_sequencer.sv
// OPB master: scratch-pad bus check, then periodic oscillator count sampling.
// Define OSC_SEQ_AVG_EN to publish a 4-sample running mean instead of raw counts.
module osc_measure_sequencer
  import osc_ct_pkg::*;
#(
  parameter int          MEAS_WAIT  = 64,
  parameter int          GAP_CYCLES = 1024,
  parameter int          FAIL_LIMIT = 3,
  parameter logic [15:0] SP_PATTERN = 16'hA5C3
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        ENABLE,
  input  logic [15:0] CNT_MIN,
  input  logic [15:0] CNT_MAX,
  output logic [31:0] OPB_ADDR,
  output logic [31:0] OSC_CT_DI,
  output logic        OSC_CT_WE,
  output logic        OSC_CT_RE,
  input  logic [31:0] OSC_CT_DO,
  output logic [15:0] LAST_COUNT,
  output logic        COUNT_VALID,
  output logic        IN_RANGE,
  output logic        FAULT,
  output logic        BUS_ERR
);

  localparam logic [15:0] HOLD_LD = 16'd1;
  localparam logic [15:0] WAIT_LD = 16'(MEAS_WAIT - 1);
  localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES - 1);

  state_t      state;
  state_t      nxt;
  bus_t        bus;
  logic [15:0] tmr;
  logic        bus_err;
  logic        sp_bad;
  logic        unused_do;

  assign sp_bad = (OSC_CT_DO[15:0] != SP_PATTERN);
  assign unused_do = ^OSC_CT_DO[31:16];

  always_comb begin
    nxt = state;
    if (!ENABLE) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (!bus_err) nxt = ST_SP_WR;
        ST_SP_WR:    nxt = ST_SP_RD;
        ST_SP_RD:    nxt = ST_SP_CHK;
        ST_SP_CHK:   nxt = sp_bad ? ST_IDLE : ST_RST_WR;
        ST_RST_WR:   nxt = ST_RST_HOLD;
        ST_RST_HOLD: if (tmr == '0) nxt = ST_START_WR;
        ST_START_WR: nxt = ST_WAIT;
        ST_WAIT:     if (tmr == '0) nxt = ST_CNT_RD;
        ST_CNT_RD:   nxt = ST_CNT_CAP;
        ST_CNT_CAP:  nxt = ST_EVAL;
        ST_EVAL:     nxt = ST_GAP;
        ST_GAP:      if (tmr == '0) nxt = ST_RST_WR;
        default:     nxt = ST_IDLE;
      endcase
    end
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
    if (OPB_RST) begin
      state   <= ST_IDLE;
      bus     <= '0;
      tmr     <= '0;
      bus_err <= 1'b0;
    end else begin
      state <= nxt;
      bus   <= bus_for(nxt, SP_PATTERN);
      if (nxt != state) begin
        case (nxt)
          ST_RST_HOLD: tmr <= HOLD_LD;
          ST_WAIT:     tmr <= WAIT_LD;
          ST_GAP:      tmr <= GAP_LD;
          default:     tmr <= '0;
        endcase
      end else if (tmr != '0) begin
        tmr <= tmr - 16'd1;
      end
      if (!ENABLE)
        bus_err <= 1'b0;
      else if (state == ST_SP_CHK && sp_bad)
        bus_err <= 1'b1;
    end
  end

  assign OPB_ADDR  = {30'h0, bus.addr};
  assign OSC_CT_DI = bus.di;
  assign OSC_CT_WE = bus.we;
  assign OSC_CT_RE = bus.re;
  assign BUS_ERR   = bus_err;

  osc_range_checker #(
    .FAIL_LIMIT(FAIL_LIMIT)
  ) u_chk (
    .clk        (OPB_CLK),
    .rst        (OPB_RST),
    .clr        (!ENABLE),
    .restart    (state == ST_IDLE),
    .cap        (state == ST_CNT_CAP),
    .cap_data   (OSC_CT_DO[15:0]),
    .cnt_min    (CNT_MIN),
    .cnt_max    (CNT_MAX),
    .last_count (LAST_COUNT),
    .count_valid(COUNT_VALID),
    .in_range   (IN_RANGE),
    .fault      (FAULT)
  );

endmodule
